enemy_target: RTL and testbench
===============================

Name: enemy_target

Overview:
- Receiving end of the bullet interface: a single enemy sprite that sweeps horizontally, watches the bullet's position and display strobe, and detects hits.
- On a hit it returns a one-cycle kill strobe, wired to the bullet's `reset` input so the bullet terminates and resyncs to the tank.
- It emits a score pulse, flashes, disappears, then respawns after a delay.
- It sits beside the bullet block in the game top level and feeds the VGA draw mux and score counter.

Parameters:
- START_X, 60, respawn/reset x (top-left of sprite)
- START_Y, 10, fixed sprite row y (top-left)
- MIN_X, 2, leftmost x the sprite may occupy
- MAX_X, 118, rightmost x the sprite may occupy; must satisfy MAX_X+SIZE-1 <= 127
- SIZE, 8, sprite width and height in pixels
- MOVE_DIV, 4, clk cycles per 1-pixel step
- HIT_CYCLES, 16, length of flash phase
- RESPAWN_CYCLES, 64, length of dead phase

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- bullet_display  input  1  bullet is in flight
- bullet_x  input  7  bullet x
- bullet_y  input  7  bullet y
- enemy_display  output  1  draw sprite this cycle
- enemy_x  output  7  sprite top-left x
- enemy_y  output  7  sprite top-left y, constant START_Y
- enemy_dir  output  1  0 = moving right, 1 = moving left
- alive  output  1  state == ALIVE
- bullet_kill  output  1  one-cycle hit strobe to bullet reset
- score_pulse  output  1  one-cycle score increment

Behaviour:
- All outputs are registered. No combinational path from inputs to outputs.
- Reset (reset=0, asynchronous):
  - state=ALIVE; enemy_x=START_X; enemy_y=START_Y; enemy_dir=0
  - move_cnt=0; phase_cnt=0
  - enemy_display=1; alive=1; bullet_kill=0; score_pulse=0
  - Reset mid-HIT or mid-DEAD returns immediately to ALIVE at START_X.
- Hit condition, evaluated on the current registered enemy_x:
  - bullet_display=1
  - enemy_x <= bullet_x <= enemy_x+SIZE-1
  - START_Y <= bullet_y <= START_Y+SIZE-1
  - Comparisons use 8-bit zero-extended sums; no 7-bit wrap.
- State ALIVE:
  - move_cnt counts 0..MOVE_DIV-1 and wraps.
  - On a cycle with move_cnt==MOVE_DIV-1 and no hit, take one step:
    - dir=0 and enemy_x==MAX_X: set dir=1, x unchanged.
    - dir=1 and enemy_x==MIN_X: set dir=0, x unchanged.
    - Otherwise x += 1 (dir=0) or x -= 1 (dir=1).
  - If the hit condition is true at edge N:
    - After edge N: state=HIT; bullet_kill=1 and score_pulse=1 for exactly one cycle (cleared at edge N+1); phase_cnt=0; alive=0.
    - Hit has priority over a simultaneous step, so x does not move.
- State HIT:
  - Bullet inputs are ignored; no further kill or score pulses.
  - phase_cnt increments each cycle; enemy_display = ~phase_cnt[1], toggling every 2 cycles, starting with 1.
  - Position is frozen.
  - When phase_cnt==HIT_CYCLES-1: state=DEAD, phase_cnt=0, enemy_display=0.
- State DEAD:
  - enemy_display=0; bullet inputs ignored; phase_cnt increments.
  - When phase_cnt==RESPAWN_CYCLES-1: state=ALIVE, enemy_x=START_X, dir=0, move_cnt=0, enemy_display=1, alive=1.
- Counters are wide enough for max(HIT_CYCLES, RESPAWN_CYCLES, MOVE_DIV)-1 and never wrap within a phase.
- A bullet arriving while the enemy is not ALIVE passes through undisturbed.

Test Plan:
- Reset, bullet_display=0, run 40 cycles -> enemy_x goes 60→70 (one step per 4 cycles); dir=0; display=1; no pulses.
- Start at x=117, dir=0, run -> x reaches 118; next step sets dir=1 with x=118; following step x=117. Mirror case at MIN_X=2.
- Enemy at x=60, y=10; drive bullet_display=1, bullet_x=67, bullet_y=17 -> next cycle: bullet_kill=1, score_pulse=1, alive=0, state HIT; both pulses drop after 1 cycle. Bullet at x=68 or y=18 -> no hit.
- After a hit -> display pattern 1,1,0,0 repeating for 16 cycles, then 0 for 64 cycles, then display=1 with x=60, dir=0; a bullet overlapping during HIT/DEAD gives no pulses.
- Hit coincident with a move step -> x unchanged and hit taken. Assert reset=0 mid-DEAD, asynchronously between edges -> outputs immediately show reset values, with x=60 and display=1.

Source files
------------

// File: rtl/enemy_target.sv
// enemy_target: single sweeping enemy sprite that detects bullet hits.
// Sweeps horizontally between MIN_X and MAX_X at START_Y. On a bullet hit it
// emits one-cycle bullet_kill and score_pulse strobes, flashes for HIT_CYCLES,
// stays hidden for RESPAWN_CYCLES, then respawns at START_X moving right.
// Ports:
//   clk            system clock, all state on rising edge
//   reset          asynchronous active-low reset
//   bullet_display bullet is in flight
//   bullet_x/y     bullet position (7 bits each)
//   enemy_display  draw sprite this cycle
//   enemy_x/y      sprite top-left position (y fixed at START_Y)
//   enemy_dir      0 = moving right, 1 = moving left
//   alive          enemy is in the ALIVE state
//   bullet_kill    one-cycle hit strobe to the bullet reset
//   score_pulse    one-cycle score increment
module enemy_target #(
  parameter int unsigned START_X        = 60,
  parameter int unsigned START_Y        = 10,
  parameter int unsigned MIN_X          = 2,
  parameter int unsigned MAX_X          = 118,
  parameter int unsigned SIZE           = 8,
  parameter int unsigned MOVE_DIV       = 4,
  parameter int unsigned HIT_CYCLES     = 16,
  parameter int unsigned RESPAWN_CYCLES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       bullet_display,
  input  logic [6:0] bullet_x,
  input  logic [6:0] bullet_y,
  output logic       enemy_display,
  output logic [6:0] enemy_x,
  output logic [6:0] enemy_y,
  output logic       enemy_dir,
  output logic       alive,
  output logic       bullet_kill,
  output logic       score_pulse
);

  localparam int unsigned MAX_AB  = (HIT_CYCLES > RESPAWN_CYCLES) ? HIT_CYCLES : RESPAWN_CYCLES;
  localparam int unsigned CNT_TOP = (MAX_AB > MOVE_DIV) ? MAX_AB : MOVE_DIV;
  localparam int unsigned CW      = (CNT_TOP <= 4) ? 2 : $clog2(CNT_TOP);

  typedef enum logic [1:0] {ALIVE, HIT, DEAD} state_t;

  state_t          state_q, state_n;
  logic [6:0]      x_n;
  logic            dir_n, disp_n, alive_n, kill_n, score_n;
  logic [CW-1:0]   move_cnt, move_cnt_n;
  logic [CW-1:0]   phase_cnt, phase_cnt_n;

  // Hit window arithmetic in 8 bits so x+SIZE-1 cannot wrap.
  logic [7:0] ex8, ex_hi, bx8, by8;
  logic       hit_c;

  assign enemy_y = 7'(START_Y);

  always_comb begin
    ex8   = {1'b0, enemy_x};
    ex_hi = ex8 + 8'(SIZE - 1);
    bx8   = {1'b0, bullet_x};
    by8   = {1'b0, bullet_y};
    hit_c = bullet_display
         && (bx8 >= ex8) && (bx8 <= ex_hi)
         && (by8 >= 8'(START_Y)) && (by8 <= 8'(START_Y + SIZE - 1));
  end

  // State register and all registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ALIVE;
      enemy_x       <= 7'(START_X);
      enemy_dir     <= 1'b0;
      move_cnt      <= '0;
      phase_cnt     <= '0;
      enemy_display <= 1'b1;
      alive         <= 1'b1;
      bullet_kill   <= 1'b0;
      score_pulse   <= 1'b0;
    end else begin
      state_q       <= state_n;
      enemy_x       <= x_n;
      enemy_dir     <= dir_n;
      move_cnt      <= move_cnt_n;
      phase_cnt     <= phase_cnt_n;
      enemy_display <= disp_n;
      alive         <= alive_n;
      bullet_kill   <= kill_n;
      score_pulse   <= score_n;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n     = state_q;
    x_n         = enemy_x;
    dir_n       = enemy_dir;
    move_cnt_n  = move_cnt;
    phase_cnt_n = phase_cnt;
    disp_n      = enemy_display;
    alive_n     = alive;
    kill_n      = 1'b0;
    score_n     = 1'b0;

    case (state_q)
      ALIVE: begin
        if (hit_c) begin
          // Hit wins over a coincident step: position stays put.
          state_n     = HIT;
          phase_cnt_n = '0;
          kill_n      = 1'b1;
          score_n     = 1'b1;
          alive_n     = 1'b0;
          disp_n      = 1'b1;
        end else if (move_cnt == CW'(MOVE_DIV - 1)) begin
          move_cnt_n = '0;
          if (!enemy_dir && enemy_x == 7'(MAX_X)) begin
            dir_n = 1'b1;
          end else if (enemy_dir && enemy_x == 7'(MIN_X)) begin
            dir_n = 1'b0;
          end else if (!enemy_dir) begin
            x_n = enemy_x + 7'd1;
          end else begin
            x_n = enemy_x - 7'd1;
          end
        end else begin
          move_cnt_n = move_cnt + CW'(1);
        end
      end

      HIT: begin
        // Flash: display follows bit 1 of the phase counter, 1,1,0,0,...
        phase_cnt_n = phase_cnt + CW'(1);
        disp_n      = ~phase_cnt_n[1];
        if (phase_cnt == CW'(HIT_CYCLES - 1)) begin
          state_n     = DEAD;
          phase_cnt_n = '0;
          disp_n      = 1'b0;
        end
      end

      DEAD: begin
        phase_cnt_n = phase_cnt + CW'(1);
        disp_n      = 1'b0;
        if (phase_cnt == CW'(RESPAWN_CYCLES - 1)) begin
          state_n     = ALIVE;
          phase_cnt_n = '0;
          x_n         = 7'(START_X);
          dir_n       = 1'b0;
          move_cnt_n  = '0;
          disp_n      = 1'b1;
          alive_n     = 1'b1;
        end
      end

      default: begin
        state_n = ALIVE;
      end
    endcase
  end

endmodule

// File: tb/tb_enemy_target.sv
// Scoreboard bench for enemy_target: stimulus pushes expected output snapshots
// tagged with a cycle number; the monitor compares them on the falling edge.
module tb_enemy_target;

  logic       clk = 1'b0;
  logic       reset;
  logic       bullet_display;
  logic [6:0] bullet_x, bullet_y;
  logic       enemy_display, enemy_dir, alive, bullet_kill, score_pulse;
  logic [6:0] enemy_x, enemy_y;

  enemy_target dut (
    .clk            (clk),
    .reset          (reset),
    .bullet_display (bullet_display),
    .bullet_x       (bullet_x),
    .bullet_y       (bullet_y),
    .enemy_display  (enemy_display),
    .enemy_x        (enemy_x),
    .enemy_y        (enemy_y),
    .enemy_dir      (enemy_dir),
    .alive          (alive),
    .bullet_kill    (bullet_kill),
    .score_pulse    (score_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [6:0] x;
    logic       dir;
    logic       disp;
    logic       alv;
    logic       kill;
    logic       score;
  } exp_t;

  exp_t q[$];
  int   cyc     = 0;
  int   n_check = 0;
  int   n_fail  = 0;
  bit   done    = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int c, input logic [6:0] x, input logic dir,
                      input logic disp, input logic alv, input logic kill,
                      input logic score);
    exp_t e;
    e.cyc = c; e.x = x; e.dir = dir; e.disp = disp;
    e.alv = alv; e.kill = kill; e.score = score;
    q.push_back(e);
  endtask

  // Monitor: compares every snapshot due at this cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      n_check++;
      if (e.cyc < cyc) begin
        n_fail++;
        $display("FAIL stale_expect cyc=%0d now=%0d", e.cyc, cyc);
      end else if (enemy_x !== e.x || enemy_dir !== e.dir ||
                   enemy_display !== e.disp || alive !== e.alv ||
                   bullet_kill !== e.kill || score_pulse !== e.score ||
                   enemy_y !== 7'd10) begin
        n_fail++;
        $display("FAIL snapshot cyc=%0d got x=%0d y=%0d dir=%b disp=%b alive=%b kill=%b score=%b exp x=%0d y=10 dir=%b disp=%b alive=%b kill=%b score=%b",
                 cyc, enemy_x, enemy_y, enemy_dir, enemy_display, alive,
                 bullet_kill, score_pulse, e.x, e.dir, e.disp, e.alv,
                 e.kill, e.score);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    if (!done) begin
      $display("FAIL watchdog timeout at cyc=%0d", cyc);
      $fatal(1, "watchdog");
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  initial begin
    int c0;
    reset          = 1'b0;
    bullet_display = 1'b0;
    bullet_x       = 7'd0;
    bullet_y       = 7'd0;

    // Reset values, then free-running sweep with no bullet.
    @(negedge clk);
    push(cyc + 1, 7'd60, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    c0 = cyc;
    for (int k = 1; k <= 40; k++)
      push(c0 + k, 7'(60 + k / 4), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    // Right wall at 118, turn, then left wall at 2, turn.
    push(c0 + 232, 7'd118, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    push(c0 + 235, 7'd118, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    push(c0 + 236, 7'd118, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    push(c0 + 239, 7'd118, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    push(c0 + 240, 7'd117, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    push(c0 + 700, 7'd2,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    push(c0 + 703, 7'd2,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    push(c0 + 704, 7'd2,   1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    push(c0 + 708, 7'd3,   1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    wait_until(c0 + 708);

    // Reset back to START_X for the hit scenarios.
    reset = 1'b0;
    push(cyc + 1, 7'd60, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    c0 = cyc;

    // Near misses (x=68, then y=18), a gap, then a hit on the step cycle.
    bullet_display = 1'b1; bullet_x = 7'd68; bullet_y = 7'd17;
    for (int k = 1; k <= 3; k++)
      push(c0 + k, 7'd60, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    push(c0 + 4, 7'd60, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int k = 5; k <= 19; k++)
      push(c0 + k, 7'd60, 1'b0, ~((k - 4) >> 1) & 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 20; k <= 83; k++)
      push(c0 + k, 7'd60, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push(c0 + 84, 7'd60, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    push(c0 + 85, 7'd60, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    push(c0 + 88, 7'd61, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

    @(negedge clk); bullet_x = 7'd67; bullet_y = 7'd18;
    @(negedge clk); bullet_display = 1'b0;
    @(negedge clk); bullet_display = 1'b1; bullet_x = 7'd67; bullet_y = 7'd17;
    // Bullet keeps overlapping through HIT and most of DEAD.
    wait_until(c0 + 80);
    bullet_display = 1'b0;

    // Second hit at the sprite's left edge, then async reset mid-DEAD.
    wait_until(c0 + 88);
    bullet_display = 1'b1; bullet_x = 7'd61; bullet_y = 7'd10;
    push(c0 + 89,  7'd61, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    push(c0 + 95,  7'd61, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push(c0 + 110, 7'd61, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    bullet_display = 1'b0;
    wait_until(c0 + 110);
    @(posedge clk);
    #2;
    reset = 1'b0;
    push(c0 + 111, 7'd60, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    push(c0 + 112, 7'd60, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    wait_until(c0 + 112);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    n_check++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_expects got=%0d exp=0", q.size());
    end
    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
    $finish;
  end

endmodule
